// File: rtl/tlc_pkg.sv
// tlc_pkg: shared lamp encodings and sequencer state type for the traffic-light sequencer.
package tlc_pkg;
   localparam logic [2:0] LT_RED = 3'b100;
   localparam logic [2:0] LT_YEL = 3'b010;
   localparam logic [2:0] LT_GRN = 3'b001;
   localparam logic [2:0] LT_OFF = 3'b000;
   typedef enum logic [1:0] {
      ST_ALL_RED = 2'd0,
      ST_GREEN   = 2'd1,
      ST_YELLOW  = 2'd2,
      ST_FLASH   = 2'd3
   } tlc_state_e;
endpackage

// File: rtl/tlc_phase_select.sv
// tlc_phase_select: cyclic priority search for the next phase to serve.
module tlc_phase_select #(
   parameter int NUM_PHASES = 4,
   localparam int PW = $clog2(NUM_PHASES)
) (
   input  logic [NUM_PHASES-1:0] pending_i,
   input  logic [PW-1:0]         phase_i,
   input  logic                  skip_en_i,
   output logic [PW-1:0]         next_o
);
   int   idx;
   logic found;
   always_comb begin
      next_o = PW'((int'(phase_i) + 1) % NUM_PHASES);
      found  = 1'b0;
      idx    = 0;
      for (int k = 1; k <= NUM_PHASES; k++) begin
         idx = (int'(phase_i) + k) % NUM_PHASES;
         if (skip_en_i && !found && pending_i[idx]) begin
            next_o = PW'(idx);
            found  = 1'b1;
         end
      end
   end
endmodule

// File: rtl/tlc_phase_sequencer.sv
// tlc_phase_sequencer: multi-phase traffic-light sequencer with demand skipping and yellow-flash mode.
module tlc_phase_sequencer
   import tlc_pkg::*;
#(
   parameter int NUM_PHASES = 4,
   parameter int NUM_DIRS   = 4,
   parameter int CNT_W      = 8,
   parameter int FLASH_HALF = 4,
   localparam int PW = $clog2(NUM_PHASES),
   localparam int BW = $clog2(FLASH_HALF + 1)
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_PHASES*NUM_DIRS-1:0] phase_mask_i,
   input  logic [NUM_PHASES*CNT_W-1:0]    cfg_green_i,
   input  logic [CNT_W-1:0]               cfg_yellow_i,
   input  logic [CNT_W-1:0]               cfg_red_i,
   input  logic [NUM_PHASES-1:0]          req_i,
   input  logic                           skip_en_i,
   input  logic                           flash_i,
   output logic [3*NUM_DIRS-1:0]          lights_o,
   output logic [PW-1:0]                  phase_o,
   output logic [1:0]                     state_o,
   output logic [CNT_W-1:0]               count_o,
   output logic [NUM_PHASES-1:0]          pending_o
);
   tlc_state_e              st_q, st_d;
   logic [PW-1:0]           phase_q, phase_d, next_phase, sel_phase;
   logic [CNT_W-1:0]        count_q, count_d, dur;
   logic [NUM_PHASES-1:0]   pending_q, pending_d, grn_entry;
   logic                    restart_q, restart_d, blink_q, blink_d, expire, in_flash, blink_wrap;
   logic [BW-1:0]           blink_cnt_q, blink_cnt_d;
   logic [3*NUM_DIRS-1:0]   lights_q, lights_d;

   // After leaving flash the search restarts as if the last phase had just been served.
   assign sel_phase = restart_q ? PW'(NUM_PHASES - 1) : phase_q;

   tlc_phase_select #(.NUM_PHASES(NUM_PHASES)) u_sel (
      .pending_i (pending_q),
      .phase_i   (sel_phase),
      .skip_en_i (skip_en_i),
      .next_o    (next_phase)
   );

   always_comb begin
      dur = st_q == ST_GREEN  ? cfg_green_i[int'(phase_q)*CNT_W +: CNT_W] :
            st_q == ST_YELLOW ? cfg_yellow_i : cfg_red_i;
      expire    = count_q >= ((dur == '0) ? '0 : dur - CNT_W'(1));
      st_d      = st_q;
      phase_d   = phase_q;
      restart_d = restart_q;
      case (st_q)
         ST_ALL_RED: if (flash_i) st_d = ST_FLASH;
                     else if (expire) begin
                        st_d      = ST_GREEN;
                        phase_d   = next_phase;
                        restart_d = 1'b0;
                     end
         ST_GREEN:   if (flash_i || expire) st_d = ST_YELLOW;
         ST_YELLOW:  if (expire) st_d = flash_i ? ST_FLASH : ST_ALL_RED;
         default:    if (!flash_i) begin
                        st_d      = ST_ALL_RED;
                        phase_d   = '0;
                        restart_d = 1'b1;
                     end
      endcase
      grn_entry   = (st_d == ST_GREEN && st_q != ST_GREEN) ? NUM_PHASES'(1) << phase_d : '0;
      pending_d   = (pending_q & ~grn_entry) | req_i;
      count_d     = (st_d != st_q) ? '0 : count_q + CNT_W'(1);
      in_flash    = st_q == ST_FLASH && st_d == ST_FLASH;
      blink_wrap  = blink_cnt_q == BW'(FLASH_HALF - 1);
      blink_cnt_d = (!in_flash || blink_wrap) ? '0 : blink_cnt_q + BW'(1);
      blink_d     = !in_flash ? 1'b0 : blink_wrap ? ~blink_q : blink_q;
      lights_d    = '0;
      for (int d = 0; d < NUM_DIRS; d++)
         lights_d[3*d +: 3] =
            st_d == ST_GREEN  ? (phase_mask_i[int'(phase_d)*NUM_DIRS + d] ? LT_GRN : LT_RED) :
            st_d == ST_YELLOW ? (phase_mask_i[int'(phase_d)*NUM_DIRS + d] ? LT_YEL : LT_RED) :
            st_d == ST_FLASH  ? (blink_d ? LT_OFF : LT_YEL) : LT_RED;
   end

   // Lamps are registered from the next state so no input reaches them combinationally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q        <= ST_ALL_RED;
         phase_q     <= '0;
         count_q     <= '0;
         pending_q   <= '0;
         restart_q   <= 1'b0;
         blink_q     <= 1'b0;
         blink_cnt_q <= '0;
         lights_q    <= {NUM_DIRS{LT_RED}};
      end else begin
         st_q        <= st_d;
         phase_q     <= phase_d;
         count_q     <= count_d;
         pending_q   <= pending_d;
         restart_q   <= restart_d;
         blink_q     <= blink_d;
         blink_cnt_q <= blink_cnt_d;
         lights_q    <= lights_d;
      end
   end

   assign lights_o  = lights_q;
   assign phase_o   = phase_q;
   assign state_o   = st_q;
   assign count_o   = count_q;
   assign pending_o = pending_q;
endmodule

// File: tb/tb_tlc_phase_sequencer.sv
// tb_tlc_phase_sequencer: directed checks of phase cycling, skipping, flash, zero green and async reset.
module tb_tlc_phase_sequencer;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] phase_mask = 16'hC3C3;
   logic [31:0] cfg_green = {8'd5, 8'd5, 8'd5, 8'd5};
   logic [7:0]  cfg_yellow = 8'd2;
   logic [7:0]  cfg_red = 8'd1;
   logic [3:0]  req = '0;
   logic        skip_en = 1'b0;
   logic        flash = 1'b0;
   logic [11:0] lights;
   logic [1:0]  phase;
   logic [1:0]  state;
   logic [7:0]  count;
   logic [3:0]  pending;
   int          n_chk = 0;
   int          n_pass = 0;

   localparam logic [11:0] L_ALLRED = 12'h924;
   localparam logic [11:0] L_G_HI   = 12'h264;
   localparam logic [11:0] L_G_LO   = 12'h909;
   localparam logic [11:0] L_Y_HI   = 12'h4A4;
   localparam logic [11:0] L_FL_ON  = 12'h492;
   localparam logic [11:0] L_FL_OFF = 12'h000;

   tlc_phase_sequencer dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .phase_mask_i (phase_mask),
      .cfg_green_i  (cfg_green),
      .cfg_yellow_i (cfg_yellow),
      .cfg_red_i    (cfg_red),
      .req_i        (req),
      .skip_en_i    (skip_en),
      .flash_i      (flash),
      .lights_o     (lights),
      .phase_o      (phase),
      .state_o      (state),
      .count_o      (count),
      .pending_o    (pending)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic expect_st(input string tag, input logic [1:0] s, input logic [1:0] p,
                            input logic [7:0] c, input logic [11:0] l);
      check({tag, "_state"}, 32'(state), 32'(s));
      check({tag, "_phase"}, 32'(phase), 32'(p));
      check({tag, "_count"}, 32'(count), 32'(c));
      check({tag, "_lights"}, 32'(lights), 32'(l));
   endtask

   initial begin
      step(2);
      rst_n = 1'b1;
      #1;
      expect_st("reset", 2'd0, 2'd0, 8'd0, L_ALLRED);
      check("reset_pending", 32'(pending), 32'h0);
      step(1);
      expect_st("g1_entry", 2'd1, 2'd1, 8'd0, L_G_HI);
      step(4);
      expect_st("g1_last", 2'd1, 2'd1, 8'd4, L_G_HI);
      step(1);
      expect_st("y1", 2'd2, 2'd1, 8'd0, L_Y_HI);
      step(2);
      expect_st("r1", 2'd0, 2'd1, 8'd0, L_ALLRED);
      step(1);
      expect_st("g2", 2'd1, 2'd2, 8'd0, L_G_LO);
      step(8);
      expect_st("g3", 2'd1, 2'd3, 8'd0, L_G_HI);
      step(8);
      expect_st("g0_wrap", 2'd1, 2'd0, 8'd0, L_G_LO);
      step(32);
      expect_st("g0_period", 2'd1, 2'd0, 8'd0, L_G_LO);
      // demand skipping: only phase 2 requested during GREEN(0)
      skip_en = 1'b1;
      req = 4'b0100;
      step(1);
      req = '0;
      check("req_latch", 32'(pending), 32'h4);
      step(7);
      expect_st("skip_g2", 2'd1, 2'd2, 8'd0, L_G_LO);
      check("skip_clr", 32'(pending), 32'h0);
      step(8);
      expect_st("skip_none", 2'd1, 2'd3, 8'd0, L_G_HI);
      step(7);
      req = 4'b0001;
      step(1);
      req = '0;
      expect_st("setwin_g0", 2'd1, 2'd0, 8'd0, L_G_LO);
      check("setwin_pend", 32'(pending), 32'h1);
      step(8);
      expect_st("reserve_g0", 2'd1, 2'd0, 8'd0, L_G_LO);
      check("reserve_pend", 32'(pending), 32'h0);
      skip_en = 1'b0;
      // flash truncation of GREEN(1)
      step(8);
      step(1);
      check("pre_flash_cnt", 32'(count), 32'd1);
      flash = 1'b1;
      step(1);
      expect_st("trunc_y1", 2'd2, 2'd1, 8'd0, L_Y_HI);
      step(2);
      check("flash_state", 32'(state), 32'd3);
      check("flash_on0", 32'(lights), 32'(L_FL_ON));
      step(3);
      check("flash_on3", 32'(lights), 32'(L_FL_ON));
      step(1);
      check("flash_off0", 32'(lights), 32'(L_FL_OFF));
      step(3);
      check("flash_off3", 32'(lights), 32'(L_FL_OFF));
      step(1);
      check("flash_on_again", 32'(lights), 32'(L_FL_ON));
      flash = 1'b0;
      step(1);
      expect_st("unflash_red", 2'd0, 2'd0, 8'd0, L_ALLRED);
      step(1);
      expect_st("unflash_g0", 2'd1, 2'd0, 8'd0, L_G_LO);
      // zero green time on phase 1
      cfg_green[15:8] = 8'd0;
      step(8);
      expect_st("zero_g1", 2'd1, 2'd1, 8'd0, L_G_HI);
      step(1);
      expect_st("zero_y1", 2'd2, 2'd1, 8'd0, L_Y_HI);
      cfg_green[15:8] = 8'd5;
      // async reset in the middle of YELLOW(2)
      step(8);
      check("y2_state", 32'(state), 32'd2);
      check("y2_phase", 32'(phase), 32'd2);
      req = 4'b0010;
      step(1);
      req = '0;
      check("y2_pend", 32'(pending), 32'h2);
      rst_n = 1'b0;
      #1;
      expect_st("async_rst", 2'd0, 2'd0, 8'd0, L_ALLRED);
      check("async_pend", 32'(pending), 32'h0);
      step(1);
      rst_n = 1'b1;
      step(1);
      expect_st("post_rst_g1", 2'd1, 2'd1, 8'd0, L_G_HI);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
